// File: rtl/vnn_pkg.sv
// Shared definitions for the NN vector streaming units: state encoding,
// the default float element width and the index-width helper.
package vnn_pkg;

  typedef enum logic {
    VS_IDLE = 1'b0,
    VS_SEND = 1'b1
  } vs_state_t;

  localparam int FP_W = 32;

  // Ceiling log2 floored at 1, so a single-beat vector still gets a 1-bit index.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vector_slice_mux.sv
// Combinational beat selector: returns LANES consecutive elements starting at
// element idx*LANES of a packed vector.
module vector_slice_mux
  import vnn_pkg::*;
#(
  parameter int VLEN  = 4,
  parameter int DW    = FP_W,
  parameter int LANES = 1,
  localparam int BEATS = VLEN / LANES,
  localparam int IW    = idx_width(VLEN / LANES)
) (
  input  logic [DW*VLEN-1:0]  data,
  input  logic [IW-1:0]       idx,
  output logic [DW*LANES-1:0] slice
);

  // Out-of-range indices (non power-of-two BEATS) read as zero rather than X.
  always_comb begin
    slice = '0;
    if (int'(idx) < BEATS) slice = data[DW*LANES*idx +: DW*LANES];
  end

endmodule

// File: rtl/vector_serializer.sv
// Captures a VLEN-element vector and streams it out LANES elements per beat
// under valid/ready, optionally re-streaming it until stop is seen.
module vector_serializer
  import vnn_pkg::*;
#(
  parameter int VLEN  = 4,
  parameter int DW    = FP_W,
  parameter int LANES = 1,
  localparam int BEATS = VLEN / LANES,
  localparam int IW    = idx_width(VLEN / LANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*VLEN-1:0]  vec,
  input  logic                loop,
  input  logic                stop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*LANES-1:0] out_data,
  output logic [IW-1:0]       out_idx,
  output logic                out_last,
  output logic                busy
);

  vs_state_t          state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               loop_q, loop_d;
  logic [DW*VLEN-1:0] vec_buf;
  logic               capture;
  logic               last_idx;

  assign last_idx = (idx_q == IW'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VS_IDLE;
      idx_q   <= '0;
      loop_q  <= 1'b0;
      vec_buf <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      if (capture) vec_buf <= vec;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    loop_d    = loop_q;
    capture   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      VS_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          loop_d  = loop;
          idx_d   = '0;
          state_d = VS_SEND;
        end
      end
      VS_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_idx) begin
            idx_d = '0;
            // A looping pass wraps in place; otherwise the vector is done.
            if (!(loop_q && !stop)) begin
              state_d = VS_IDLE;
              loop_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = VS_IDLE;
    endcase
  end

  assign busy     = (state_q != VS_IDLE);
  assign out_idx  = idx_q;
  assign out_last = (state_q == VS_SEND) && last_idx && (!loop_q || stop);

  vector_slice_mux #(
    .VLEN  (VLEN),
    .DW    (DW),
    .LANES (LANES)
  ) u_slice_mux (
    .data  (vec_buf),
    .idx   (idx_q),
    .slice (out_data)
  );

endmodule

// File: tb/tb_vector_serializer.sv
// Directed bench for vector_serializer: a one-lane and a two-lane instance,
// checked every cycle against a queue of expected beats plus literal sequences.
module tb_vector_serializer;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] idx;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] vec = '0;

  logic        in_valid1 = 1'b0, loop1 = 1'b0, stop1 = 1'b0, out_ready1 = 1'b1;
  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [31:0] out_data1;
  logic [1:0]  out_idx1;

  logic        in_valid2 = 1'b0, loop2 = 1'b0, stop2 = 1'b0, out_ready2 = 1'b1;
  logic        in_ready2, out_valid2, out_last2, busy2;
  logic [63:0] out_data2;
  logic [0:0]  out_idx2;

  int checks = 0;
  int errors = 0;

  beat_t       q1[$];
  beat_t       q2[$];
  logic [31:0] got[$];

  always #5 clk = ~clk;

  vector_serializer #(.VLEN(4), .DW(32), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .vec(vec),
    .loop(loop1), .stop(stop1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1), .busy(busy1)
  );

  vector_serializer #(.VLEN(4), .DW(32), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .vec(vec),
    .loop(loop2), .stop(stop2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected beats: element i is v[32*i +: 32]; beat b carries elements
  // b*lanes .. b*lanes+lanes-1; only the final beat of the final pass is last.
  task automatic push_model(input int sel, input logic [127:0] v, input int passes);
    logic [31:0] e[4];
    int lanes;
    beat_t bt;
    lanes = (sel == 1) ? 1 : 2;
    for (int i = 0; i < 4; i++) e[i] = v[32*i +: 32];
    for (int p = 0; p < passes; p++) begin
      for (int b = 0; b < 4 / lanes; b++) begin
        bt.data = '0;
        for (int j = 0; j < lanes; j++) bt.data |= 64'(e[b*lanes + j]) << (32 * j);
        bt.idx  = b;
        bt.last = (p == passes - 1) && (b == 4 / lanes - 1);
        if (sel == 1) q1.push_back(bt); else q2.push_back(bt);
      end
    end
  endtask

  // Compare process: every accepted beat must match the model head, and a
  // stalled beat must still be presented unchanged on the next cycle.
  logic        hold1 = 1'b0;
  logic [31:0] hd1;
  logic [1:0]  hi1;
  logic        hl1;
  always @(negedge clk) begin
    beat_t bt;
    if (!rst && hold1) begin
      chk("hold_valid", 64'(out_valid1), 64'd1);
      chk("hold_data", 64'(out_data1), 64'(hd1));
      chk("hold_idx", 64'(out_idx1), 64'(hi1));
      chk("hold_last", 64'(out_last1), 64'(hl1));
    end
    hold1 <= !rst && out_valid1 && !out_ready1;
    hd1 <= out_data1; hi1 <= out_idx1; hl1 <= out_last1;
    if (!rst && out_valid1 && out_ready1) begin
      got.push_back(out_data1);
      if (q1.size() == 0) chk("unexpected_beat1", 64'(out_data1), 64'hDEAD);
      else begin
        bt = q1.pop_front();
        chk("beat1_data", 64'(out_data1), bt.data);
        chk("beat1_idx", 64'(out_idx1), 64'(bt.idx));
        chk("beat1_last", 64'(out_last1), 64'(bt.last));
      end
    end
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) chk("unexpected_beat2", out_data2, 64'hDEAD);
      else begin
        bt = q2.pop_front();
        chk("beat2_data", out_data2, bt.data);
        chk("beat2_idx", 64'(out_idx2), 64'(bt.idx));
        chk("beat2_last", 64'(out_last2), 64'(bt.last));
      end
    end
  end

  task automatic send1(input logic [127:0] v, input logic lp, input int passes);
    @(posedge clk); #1;
    chk("in_ready_idle", 64'(in_ready1), 64'd1);
    vec = v; loop1 = lp; in_valid1 = 1'b1;
    push_model(1, v, passes);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("first_valid", 64'(out_valid1), 64'd1);
    chk("first_idx", 64'(out_idx1), 64'd0);
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while ((busy1 || q1.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic wait_idx1(input int target);
    int n;
    n = 0;
    while (!(out_valid1 && out_idx1 == 2'(target)) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_idx_timeout", 64'(n < 50), 64'd1);
  endtask

  task automatic chk_got(input string name, input logic [31:0] exp[$]);
    chk({name, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, 64'(got[i]), 64'(exp[i]));
  endtask

  localparam logic [127:0] V1 = {32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [127:0] VA = {32'hD, 32'hC, 32'hB, 32'hA};

  initial begin
    logic [31:0] seq[$];
    int n;
    #2;
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_out_data", 64'(out_data1), 64'd0);
    chk("rst_out_last", 64'(out_last1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_out_data2", out_data2, 64'd0);
    #10 rst = 1'b0;

    // Basic stream: four back-to-back beats, ready again right after.
    send1(V1, 1'b0, 1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("basic_last", 64'(out_last1), 64'(i == 3));
    end
    @(posedge clk); #1;
    chk("basic_in_ready_after", 64'(in_ready1), 64'd1);
    chk("basic_busy_after", 64'(busy1), 64'd0);
    seq = '{32'h1, 32'h2, 32'h3, 32'h4};
    chk_got("basic_seq", seq);
    got.delete();

    // Backpressure on beat 2 for three cycles.
    send1(V1, 1'b0, 1);
    wait_idx1(2);
    out_ready1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_data", 64'(out_data1), 64'h3);
      chk("bp_idx", 64'(out_idx1), 64'd2);
    end
    out_ready1 = 1'b1;
    wait_idle1();
    chk_got("bp_seq", seq);
    got.delete();

    // Loop mode: stop raised while pass 2 shows beat 1.
    send1(V1, 1'b1, 2);
    n = 0;
    while (got.size() < 5 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("loop_wait_timeout", 64'(n < 50), 64'd1);
    chk("loop_pass2_idx", 64'(out_idx1), 64'd1);
    stop1 = 1'b1;
    wait_idle1();
    stop1 = 1'b0;
    seq = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h1, 32'h2, 32'h3, 32'h4};
    chk_got("loop_seq", seq);
    got.delete();

    // Asynchronous reset between edges while beat 2 is presented.
    send1(V1, 1'b0, 1);
    wait_idx1(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid1), 64'd0);
    chk("arst_out_data", 64'(out_data1), 64'd0);
    chk("arst_out_last", 64'(out_last1), 64'd0);
    chk("arst_busy", 64'(busy1), 64'd0);
    chk("arst_in_ready", 64'(in_ready1), 64'd1);
    q1.delete();
    got.delete();
    #3 rst = 1'b0;
    send1(VA, 1'b0, 1);
    chk("arst_restart_data", 64'(out_data1), 64'hA);
    wait_idle1();
    seq = '{32'hA, 32'hB, 32'hC, 32'hD};
    chk_got("arst_seq", seq);

    // Two lanes per beat.
    @(posedge clk); #1;
    chk("lanes_in_ready", 64'(in_ready2), 64'd1);
    vec = V1; in_valid2 = 1'b1;
    push_model(2, V1, 1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    chk("lanes_beat0", out_data2, 64'h00000002_00000001);
    chk("lanes_beat0_last", 64'(out_last2), 64'd0);
    @(posedge clk); #1;
    chk("lanes_beat1", out_data2, 64'h00000004_00000003);
    chk("lanes_beat1_last", 64'(out_last2), 64'd1);
    @(posedge clk); #1;
    chk("lanes_in_ready_after", 64'(in_ready2), 64'd1);
    chk("lanes_drain", 64'(q2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vector_serializer.md
# vector_serializer

Streams a buffered vector of `VLEN` floating-point elements out as `LANES` elements per beat, under valid/ready handshakes on both sides. It replaces free-running per-clock element muxing wherever a downstream unit (MAC, activation, FIFO) can stall. It sits between layer-output registers and serial arithmetic consumers in the NN datapath. An optional loop mode re-streams the captured vector until told to stop, for weight/input reuse.

## Interface
- `VLEN`, 4, number of elements per vector; must be a multiple of `LANES`
- `DW`, 32, element width in bits (IEEE-754 single by default)
- `LANES`, 1, elements emitted per output beat
- Derived: `BEATS = VLEN/LANES`; `IW = max(1, $clog2(BEATS))`

Ports:
- `clk` in 1, sole clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `in_valid` in 1, `vec`/`loop` valid
- `in_ready` out 1, block can capture a vector
- `vec` in `DW*VLEN`, element i at `vec[DW*i +: DW]`
- `loop` in 1, sampled with `vec`; 1 = repeat vector until `stop`
- `stop` in 1, level; ends loop mode after the current pass
- `out_valid` out 1, beat available
- `out_ready` in 1, consumer accepts beat
- `out_data` out `DW*LANES`, lane j = element `idx*LANES + j` at `[DW*j +: DW]`
- `out_idx` out `IW`, beat index of current beat
- `out_last` out 1, current beat is beat `BEATS-1` of a pass that will not repeat
- `busy` out 1, high whenever state is not IDLE

## Operation
- FSM with two states, IDLE and SEND.
- IDLE:
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid`: capture `vec` into `buf`, capture `loop` into `loop_r`, set `idx=0`, go to SEND.
- SEND:
  - `out_valid=1`, `out_data=buf[DW*LANES*idx +: DW*LANES]`, `in_ready=0`.
  - Beat accepted when `out_valid & out_ready`.
  - Accepted beat with `idx<BEATS-1`: `idx++`.
  - Accepted beat with `idx==BEATS-1`:
    - `loop_r=1` and `stop=0`: `idx` wraps to 0 and the block stays in SEND.
    - Otherwise: `idx=0`, go to IDLE, clear `loop_r`.
- `out_last = (idx==BEATS-1) & (~loop_r | stop)`. It is combinational from registers and `stop`.
- `stop` while in IDLE, or with `loop_r=0`, has no effect.
- `stop` deasserted before the last beat is accepted leaves looping in effect.
- `buf` is written only on capture. `vec` changes during SEND are ignored.
- `BEATS==1`: every accepted beat is last. `idx` stays 0.

## Timing
- Reset values (async on `rst`): state IDLE, `idx=0`, `buf=0`, `loop_r=0`.
  - Outputs under reset: `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`, `in_ready=1`.
- Capture handshake at edge k makes `out_valid=1` with beat 0 in the cycle after edge k. Latency is 1 cycle.
- Non-loop vector with `out_ready` held high: `BEATS` output cycles.
  - `in_ready` returns 1 in the cycle after the last accept.
  - Throughput is one vector per `BEATS+1` cycles. The one-cycle bubble is intended.
- Backpressure:
  - While `out_valid & ~out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
  - `out_valid` never drops without an accept.
- `rst` asserted mid-stream aborts immediately. The partial vector is discarded.
- `in_valid` during SEND is ignored; the upstream source must hold it.

## Structure
- Shared package `vnn_pkg`:
  - state encoding (`VS_IDLE`, `VS_SEND`)
  - `FP_W=32` constant
  - a `clog2`-floor-1 helper function used for `IW`
- Sub-module `vector_slice_mux`: combinational, parameters `VLEN/DW/LANES`, selects beat `idx` from `buf`. It is reusable by other serial units.
- The FSM, `idx` counter and capture register live in `vector_serializer`.

## Test plan
- Basic stream:
  - Setup: VLEN=4, DW=32, LANES=1, `vec={32'h4,32'h3,32'h2,32'h1}`, `loop=0`, `out_ready=1`.
  - Required: `out_data` = 1,2,3,4 on 4 consecutive cycles; `out_idx` = 0..3; `out_last` only on the 4th beat; `in_ready=1` the following cycle.
- Backpressure:
  - Stimulus: as basic stream, with `out_ready` low for 3 cycles on beat 2.
  - Required: `out_data=32'h3` and `out_idx=2` held for all 3 cycles; no beat lost or duplicated.
- Lanes:
  - Setup: VLEN=4, LANES=2, same `vec`.
  - Required: beat0 `out_data={32'h2,32'h1}`, beat1 `{32'h4,32'h3}` with `out_last=1`.
- Loop mode:
  - Stimulus: `loop=1`; `stop` asserted during the 2nd pass at beat 1.
  - Required: sequence 1,2,3,4,1,2,3,4, then IDLE; `out_last` only on the 8th beat.
- Reset mid-stream:
  - Stimulus: `rst` pulsed asynchronously (between edges) during beat 2.
  - Required: outputs go to reset values immediately; the next capture of `vec={..,32'hA}` streams from idx 0 with `out_data=32'hA`.
